// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Each grant runs a fixed-length memory access and then pulses the owner's ack.
// A simultaneous request from both sides is settled by a round-robin priority bit.
module data_mem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int SIZE        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [63:0] addr0,
    input  logic [63:0] addr1,
    input  logic [63:0] wdata0,
    input  logic [63:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [63:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        owner,
    output logic [63:0] mem_address,
    output logic [63:0] mem_indata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_outread
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Counter value on the final ACCESS cycle. WAIT_CYCLES is at most 15, so 4 bits suffice.
    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
    localparam logic [63:0] SIZE_W   = 64'(SIZE);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic        oor_q, oor_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        grant_sel;

    // State and datapath registers, all cleared by synchronous reset.
    // NOTE: non-blocking assignments here keep every flop sampling the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: arbitration and capture in IDLE, wait counting in ACCESS, priority hand-off in DONE.
    always_comb begin
        // NOTE: every signal takes its hold value first so no path through the case leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        we_d      = we_q;
        oor_d     = oor_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        grant_sel = (req0 && req1) ? prio_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant_sel;
                    addr_d  = grant_sel ? addr1  : addr0;
                    we_d    = grant_sel ? we1    : we0;
                    wdata_d = grant_sel ? wdata1 : wdata0;
                    oor_d   = (addr_d >= SIZE_W);
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    // Reads capture the memory word on the last cycle; writes and rejected addresses return 0.
                    rdata_d = (!we_q && !oor_q) ? mem_outread : '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: memory strobes only during ACCESS, ack and err only in DONE.
    always_comb begin
        ack0        = 1'b0;
        ack1        = 1'b0;
        err         = 1'b0;
        busy        = (state_q != IDLE);
        owner       = owner_q;
        rdata       = rdata_q;
        mem_address = '0;
        mem_indata  = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;

        case (state_q)
            ACCESS: begin
                mem_address = addr_q;
                mem_indata  = wdata_q;
                mem_read    = !we_q && !oor_q;
                mem_write   = we_q && !oor_q && (cnt_q == LAST_CNT);
            end
            DONE: begin
                ack0 = !owner_q;
                ack1 = owner_q;
                err  = oor_q;
            end
            default: begin
            end
        endcase
    end

endmodule
